mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath. Sits directly upstream of the ALU.
- Two asynchronous read ports drive the ALU's in1 and in2 operand paths (read port 2 goes through the ALUSrc mux). One synchronous write port takes the writeback result (ALU out or memory data).
- Register $zero is hardwired to 0. $sp and $gp take programmable values on reset.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width (2**ADDR_W entries)
- SP_INIT, 32'h7FFF_EFFC, value loaded into r29 ($sp) on reset
- GP_INIT, 32'h1000_8000, value loaded into r28 ($gp) on reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- reg_write  input  1  write enable from main control (RegWrite)
- read_reg1  input  ADDR_W  read port 1 index (instr rs)
- read_reg2  input  ADDR_W  read port 2 index (instr rt)
- write_reg  input  ADDR_W  write index (rt or rd after RegDst mux)
- write_data  input  DATA_W  writeback value
- read_data1  output  DATA_W  contents of read_reg1, to ALU in1
- read_data2  output  DATA_W  contents of read_reg2, to ALUSrc mux / memory write data

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n. No asynchronous paths into state.
- Reset:
  - At a rising edge with rst_n=0, r29 <= SP_INIT, r28 <= GP_INIT, and every other entry <= 0.
  - reg_write is ignored on that edge: reset has priority over write.
  - Reset asserted mid-program takes effect on the next edge regardless of in-flight writeback.
  - Reset held for N cycles behaves the same as reset held for 1 cycle.
- Write:
  - At a rising edge with rst_n=1, reg_write=1 and write_reg!=0: entry[write_reg] <= write_data.
  - write_reg=0 with reg_write=1 is silently discarded; r0 storage never changes.
- Read:
  - Combinational, zero latency.
  - read_dataN = 0 when read_regN==0; otherwise read_dataN = entry[read_regN].
  - Outputs are not registered. Both ports may address the same entry simultaneously.
  - Before the first reset edge, outputs are undefined (X in simulation). After the reset edge: read of r0 is 0, r28 is GP_INIT, r29 is SP_INIT, all others are 0.
- Read/write collision (read_regN==write_reg, reg_write=1, same cycle):
  - The read returns the OLD contents until the edge and the new value after it. This is the required single-cycle semantics.
  - Bypass behaviour is described under Optional Feature.
- Width rules:
  - No extension or truncation; all data paths are DATA_W.
  - Indices use the full ADDR_W range, no out-of-range case.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read port whose index equals write_reg, with reg_write=1 and write_reg!=0, outputs write_data combinationally in the same cycle (write-through forwarding, for a later pipelined build).
  - The r0 rule still wins: a read of r0 always returns 0.
  - Reset does not gate the bypass: the bypass depends only on reg_write/write_reg/write_data.
- Undefined: no bypass; collision returns the old contents as stated above.

Decomposition:
- Shared package mips_pkg:
  - DATA_W/ADDR_W defaults
  - register index constants REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31
  - SP/GP reset defaults
  - the ALU ctrl encodings already used by the datapath, so that all stages pull from one place
- One sub-module is natural: regfile_read_port.
  - Function: index -> data mux with the r0 force-to-zero and optional bypass compare.
  - Instantiated twice for read_data1 and read_data2.
- Storage array and write/reset logic stay in mips_reg_file.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 edges, with reg_write=1, write_reg=5, write_data=32'hDEAD_BEEF held throughout, then release.
  - Required: read r5=0, r28=32'h1000_8000, r29=32'h7FFF_EFFC, r0=0, and no write landed.
- Basic write/read:
  - Stimulus: write r8=32'h0000_0005, then r9=32'hFFFF_FFFB on consecutive edges; read_reg1=8, read_reg2=9.
  - Required: read_data1=5, read_data2=32'hFFFF_FFFB; both ports reading r8 return 5 on both.
- $zero protection:
  - Stimulus: reg_write=1, write_reg=0, write_data=32'h1234_5678, one edge.
  - Required: read_reg1=0 gives 0; collision with read_reg1=0 during the write also gives 0, in both macro builds.
- Collision without REGFILE_WRITE_BYPASS_EN:
  - Stimulus: r10=32'hAAAA_0000 stored; same cycle reg_write=1, write_reg=10, write_data=32'h5555_0001, read_reg1=10.
  - Required: read_data1=32'hAAAA_0000 before the edge, 32'h5555_0001 after it.
  - With the macro defined: read_data1=32'h5555_0001 before the edge.
- Reset mid-operation:
  - Stimulus: r29 written to 32'h0000_1000, then rst_n=0 for one edge while reg_write=1, write_reg=29, write_data=32'h0000_2000.
  - Required: read r29=32'h7FFF_EFFC after the edge.
- Write-enable gating:
  - Stimulus: reg_write=0, write_reg=3, write_data=32'hFFFF_FFFF for 4 edges.
  - Required: r3 stays at its prior value (0 after reset).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, architectural register indices, reset values, ALU control codes.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

endpackage

// File: rtl/regfile_read_port.sv
// Register file read mux with $zero forced to 0; optional write-through bypass (REGFILE_WRITE_BYPASS_EN).
// Latency: combinational, zero cycles; no backpressure.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs_i,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                               wr_en_i,
    input  logic [ADDR_W-1:0]                  wr_idx_i,
    input  logic [DATA_W-1:0]                  wr_dat_i,
`endif
    input  logic [ADDR_W-1:0]                  rd_idx_i,
    output logic [DATA_W-1:0]                  rd_dat_o
);

    always_comb begin
        rd_dat_o = regs_i[rd_idx_i];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_dat_o = wr_dat_i;
        end
`endif
        // r0 wins over the bypass, so a write to index 0 never leaks through.
        if (rd_idx_i == '0) begin
            rd_dat_o = '0;
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// 32-entry MIPS GPR file: two async read ports, one sync write port, sync active-low reset seeding $sp/$gp.
// Latency: reads combinational, writes visible after the edge; no backpressure. Optional: REGFILE_WRITE_BYPASS_EN.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int              DATA_W  = DATA_W_DEF,
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEF,
    parameter logic [DATA_W-1:0] GP_INIT = GP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;

    // Reset has priority over any in-flight writeback.
    always_comb begin
        regs_d = regs_q;
        if (!rst_n) begin
            regs_d         = '0;
            regs_d[REG_SP] = SP_INIT;
            regs_d[REG_GP] = GP_INIT;
        end else if (reg_write && (write_reg != '0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
        .regs_i   (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wr_en_i  (reg_write),
        .wr_idx_i (write_reg),
        .wr_dat_i (write_data),
`endif
        .rd_idx_i (read_reg1),
        .rd_dat_o (read_data1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
        .regs_i   (regs_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wr_en_i  (reg_write),
        .wr_idx_i (write_reg),
        .wr_dat_i (write_data),
`endif
        .rd_idx_i (read_reg2),
        .rd_dat_o (read_data2)
    );

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed plus randomized checks of mips_reg_file against an array-based architectural model.
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    logic [31:0] model [32];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mips_reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Architectural expectation for a read in the current cycle.
    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reg_write && write_reg == idx) return write_data;
`endif
        return model[idx];
    endfunction

    // One rising edge: the model applies the same architectural rules.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[29] = 32'h7FFF_EFFC;
            model[28] = 32'h1000_8000;
        end else if (reg_write && write_reg != 5'd0) begin
            model[write_reg] = write_data;
        end
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        read_reg1 = a;
        read_reg2 = b;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic bypass;
`ifdef REGFILE_WRITE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        // Reset for two edges with a write held on the bus.
        rst_n = 1'b0; reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        tick(); tick();
        rst_n = 1'b1; reg_write = 1'b0;
        rd(5'd5, 5'd0);
        check("rst_r5", read_data1, 32'h0);
        check("rst_r0", read_data2, 32'h0);
        rd(5'd28, 5'd29);
        check("rst_gp", read_data1, 32'h1000_8000);
        check("rst_sp", read_data2, 32'h7FFF_EFFC);

        // Basic write/read.
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h0000_0005; tick();
        write_reg = 5'd9; write_data = 32'hFFFF_FFFB; tick();
        reg_write = 1'b0;
        rd(5'd8, 5'd9);
        check("wr_r8", read_data1, 32'h0000_0005);
        check("wr_r9", read_data2, 32'hFFFF_FFFB);
        rd(5'd8, 5'd8);
        check("same_p1", read_data1, 32'h0000_0005);
        check("same_p2", read_data2, 32'h0000_0005);

        // $zero protection, including collision in both builds.
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
        rd(5'd0, 5'd0);
        check("zero_coll", read_data1, 32'h0);
        tick();
        reg_write = 1'b0;
        rd(5'd0, 5'd8);
        check("zero_after", read_data1, 32'h0);

        // Read/write collision.
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'hAAAA_0000; tick();
        write_data = 32'h5555_0001;
        rd(5'd10, 5'd0);
        check("coll_pre", read_data1, bypass ? 32'h5555_0001 : 32'hAAAA_0000);
        tick();
        reg_write = 1'b0;
        rd(5'd10, 5'd0);
        check("coll_post", read_data1, 32'h5555_0001);

        // Reset mid-operation overrides an in-flight write to $sp.
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h0000_1000; tick();
        rd(5'd29, 5'd0);
        reg_write = 1'b0;
        rd(5'd29, 5'd0);
        check("sp_written", read_data1, 32'h0000_1000);
        rst_n = 1'b0; reg_write = 1'b1; write_data = 32'h0000_2000; tick();
        rst_n = 1'b1; reg_write = 1'b0;
        rd(5'd29, 5'd10);
        check("rst_mid_sp", read_data1, 32'h7FFF_EFFC);
        check("rst_mid_r10", read_data2, 32'h0);

        // Write enable gating.
        reg_write = 1'b0; write_reg = 5'd3; write_data = 32'hFFFF_FFFF;
        repeat (4) tick();
        rd(5'd3, 5'd3);
        check("we_gate", read_data1, 32'h0);

        // Randomized traffic, biased toward collisions and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            reg_write  = $urandom_range(0, 1) != 0;
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rnd%0d_p1_r%0d", i, read_reg1), read_data1, exp_rd(read_reg1));
            check($sformatf("rnd%0d_p2_r%0d", i, read_reg2), read_data2, exp_rd(read_reg2));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
